// File: rtl/vga_data_refresher.sv
// rtl/vga_data_refresher.sv - sweeps the register mirror into the overlay stage during each VSync-low window
// Each address is read over RdReq/RdAck, BCD-checked, then strobed out on CS_DATA.
module vga_data_refresher #(
  parameter logic [3:0] FIRST_ADDR = 4'd1,
  parameter logic [3:0] LAST_ADDR  = 4'd12,
  parameter logic [3:0] BCD_LAST   = 4'd9,
  parameter logic [7:0] TIMEOUT    = 8'd15
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       VSync,
  output logic       RdReq,
  output logic [3:0] RdAddr,
  input  logic       RdAck,
  input  logic [7:0] RdData,
  output logic [3:0] MemAddrOut,
  output logic [7:0] MemDataOut,
  output logic       CS_DATA,
  output logic       Busy,
  output logic       SweepDone,
  input  logic       ClrErr,
  output logic       Overrun,
  output logic       TimeoutErr,
  output logic       BcdErr
);

  typedef enum logic [1:0] {IDLE, REQ, WRITE, DONE} state_t;

  state_t     state;
  logic [3:0] addr;
  logic       vs_q;
  logic [7:0] wait_cnt;
  logic [7:0] wait_next;
  logic       start;
  logic       timeout_hit;
  logic       bcd_bad;

  assign start       = vs_q & ~VSync;
  assign wait_next   = wait_cnt + 8'd1;
  assign timeout_hit = (wait_next == TIMEOUT);
  assign bcd_bad     = (addr <= BCD_LAST) && ((RdData[7:4] > 4'd9) || (RdData[3:0] > 4'd9));

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state      <= IDLE;
      addr       <= FIRST_ADDR;
      vs_q       <= 1'b1;
      wait_cnt   <= 8'd0;
      RdReq      <= 1'b0;
      RdAddr     <= 4'd0;
      MemAddrOut <= 4'd0;
      MemDataOut <= 8'd0;
      CS_DATA    <= 1'b0;
      Busy       <= 1'b0;
      SweepDone  <= 1'b0;
      Overrun    <= 1'b0;
      TimeoutErr <= 1'b0;
      BcdErr     <= 1'b0;
    end else begin
      vs_q      <= VSync;
      CS_DATA   <= 1'b0;
      SweepDone <= 1'b0;
      // Clear first so that any set below in the same cycle takes precedence.
      if (ClrErr) begin
        Overrun    <= 1'b0;
        TimeoutErr <= 1'b0;
        BcdErr     <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (start) begin
            state    <= REQ;
            addr     <= FIRST_ADDR;
            RdAddr   <= FIRST_ADDR;
            RdReq    <= 1'b1;
            Busy     <= 1'b1;
            wait_cnt <= 8'd0;
          end
        end
        REQ: begin
          if (vs_q) begin
            state    <= IDLE;
            RdReq    <= 1'b0;
            Busy     <= 1'b0;
            addr     <= FIRST_ADDR;
            wait_cnt <= 8'd0;
            Overrun  <= 1'b1;
          end else if (RdAck) begin
            state      <= WRITE;
            RdReq      <= 1'b0;
            CS_DATA    <= 1'b1;
            MemAddrOut <= addr;
            MemDataOut <= bcd_bad ? 8'h00 : RdData;
            if (bcd_bad) BcdErr <= 1'b1;
          end else if (timeout_hit) begin
            // Reuse the WRITE slot without a strobe so the address advances identically.
            state      <= WRITE;
            RdReq      <= 1'b0;
            wait_cnt   <= 8'd0;
            TimeoutErr <= 1'b1;
          end else begin
            wait_cnt <= wait_next;
          end
        end
        WRITE: begin
          if (addr == LAST_ADDR) begin
            state <= DONE;
          end else begin
            state    <= REQ;
            addr     <= addr + 4'd1;
            RdAddr   <= addr + 4'd1;
            RdReq    <= 1'b1;
            wait_cnt <= 8'd0;
          end
        end
        DONE: begin
          state     <= IDLE;
          SweepDone <= 1'b1;
          Busy      <= 1'b0;
          addr      <= FIRST_ADDR;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_data_refresher.sv
// tb/tb_vga_data_refresher.sv - self-checking bench for vga_data_refresher
// A behavioural mirror answers reads after a per-address latency; sweeps are checked against an arithmetic model.
module tb_vga_data_refresher;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       VSync = 1'b1;
  logic       RdAck = 1'b0;
  logic [7:0] RdData = 8'h00;
  logic       ClrErr = 1'b0;
  logic       RdReq, CS_DATA, Busy, SweepDone, Overrun, TimeoutErr, BcdErr;
  logic [3:0] RdAddr, MemAddrOut;
  logic [7:0] MemDataOut;

  vga_data_refresher dut (
    .CLK(CLK), .RESET(RESET), .VSync(VSync), .RdReq(RdReq), .RdAddr(RdAddr),
    .RdAck(RdAck), .RdData(RdData), .MemAddrOut(MemAddrOut), .MemDataOut(MemDataOut),
    .CS_DATA(CS_DATA), .Busy(Busy), .SweepDone(SweepDone), .ClrErr(ClrErr),
    .Overrun(Overrun), .TimeoutErr(TimeoutErr), .BcdErr(BcdErr)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {logic [3:0] a; logic [7:0] d;} wr_t;
  typedef struct {logic [3:0] a; logic [7:0] d; logic [7:0] exp_d; logic exp_err;} vec_t;

  logic [7:0] mem [16];
  int         lat [16];       // REQ cycles before the mirror acks; >=15 means never inside the window
  wr_t        wq[$];
  int         req_run = 0;
  int         req_len [16];
  logic       bcd_at_write [16];
  int         sd_count = 0, sd_cyc = -1, first_req_cyc = -1;
  logic [3:0] first_req_addr = 4'd0;
  int         checks = 0, errors = 0;

  // Mirror model and output monitor, evaluated on the falling edge.
  always @(negedge CLK) begin
    if (RdReq) begin
      if (req_run == 0 && first_req_cyc < 0) begin
        first_req_cyc  = cyc;
        first_req_addr = RdAddr;
      end
      req_run++;
      req_len[RdAddr] = req_run;
      RdAck  = ((req_run - 1) == lat[RdAddr]);
      RdData = mem[RdAddr];
    end else begin
      req_run = 0;
      RdAck   = 1'b0;
      RdData  = 8'h00;
    end
    if (CS_DATA) begin
      wq.push_back('{MemAddrOut, MemDataOut});
      bcd_at_write[MemAddrOut] = BcdErr;
    end
    if (SweepDone) begin
      sd_count++;
      sd_cyc = cyc;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  function automatic logic [7:0] bcd_fix(input logic [3:0] a, input logic [7:0] d);
    if (a <= 4'd9 && (d[7:4] > 4'd9 || d[3:0] > 4'd9)) return 8'h00;
    return d;
  endfunction

  function automatic logic [31:0] all_outputs();
    return {RdReq, RdAddr, MemAddrOut, MemDataOut, CS_DATA, Busy, SweepDone, Overrun, TimeoutErr, BcdErr};
  endfunction

  task automatic fill(input logic [7:0] d, input int l);
    for (int a = 0; a < 16; a++) begin
      mem[a] = d;
      lat[a] = l;
    end
  endtask

  task automatic clear_records();
    wq.delete();
    sd_count = 0;
    sd_cyc = -1;
    first_req_cyc = -1;
    for (int a = 0; a < 16; a++) begin
      req_len[a] = 0;
      bcd_at_write[a] = 1'b0;
    end
  endtask

  task automatic run_sweep(input logic hold_clr);
    int n;
    VSync = 1'b1;
    ClrErr = 1'b1;
    tick();
    ClrErr = hold_clr;
    tick();
    clear_records();
    VSync = 1'b0;
    n = 0;
    while (sd_count == 0 && n < 400) begin
      tick();
      n++;
    end
    tick();
    VSync = 1'b1;
    ClrErr = 1'b0;
    tick();
  endtask

  task automatic check_sweep(input string tag);
    wr_t  exp_q[$];
    int   dt = 0;
    logic exp_to = 1'b0, exp_bcd = 1'b0;
    for (int a = 1; a <= 12; a++) begin
      if (lat[a] <= 14) begin
        exp_q.push_back('{a[3:0], bcd_fix(a[3:0], mem[a])});
        if (bcd_fix(a[3:0], mem[a]) != mem[a]) exp_bcd = 1'b1;
        dt += lat[a] + 2;
      end else begin
        exp_to = 1'b1;
        dt += 16;
      end
    end
    check($sformatf("%s write_count", tag), wq.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < wq.size())
        check($sformatf("%s write[%0d]", tag, i), {wq[i].a, wq[i].d}, {exp_q[i].a, exp_q[i].d});
    check($sformatf("%s first_req_addr", tag), first_req_addr, 1);
    check($sformatf("%s sweepdone_count", tag), sd_count, 1);
    check($sformatf("%s sweepdone_delay", tag), sd_cyc - first_req_cyc, dt + 1);
    check($sformatf("%s flags", tag), {Overrun, TimeoutErr, BcdErr, Busy}, {1'b0, exp_to, exp_bcd, 1'b0});
  endtask

  vec_t vt [8];

  initial begin
    int n;
    vt[0] = '{4'd2,  8'h3A, 8'h00, 1'b1};
    vt[1] = '{4'd11, 8'hFF, 8'hFF, 1'b0};
    vt[2] = '{4'd9,  8'h9A, 8'h00, 1'b1};
    vt[3] = '{4'd9,  8'h99, 8'h99, 1'b0};
    vt[4] = '{4'd10, 8'hA5, 8'hA5, 1'b0};
    vt[5] = '{4'd1,  8'hF0, 8'h00, 1'b1};
    vt[6] = '{4'd12, 8'h0B, 8'h0B, 1'b0};
    vt[7] = '{4'd5,  8'h59, 8'h59, 1'b0};
    fill(8'h37, 0);

    repeat (3) tick();
    check("reset outputs", all_outputs(), 0);
    RESET = 1'b1;
    tick();
    check("idle after reset", {Busy, RdReq}, 0);

    run_sweep(1'b0);
    check_sweep("nominal");
    check("nominal sweepdone 25", sd_cyc - first_req_cyc, 25);

    for (int i = 0; i < 8; i++) begin
      logic [7:0] got;
      got = 8'hxx;
      fill(8'h37, 0);
      mem[vt[i].a] = vt[i].d;
      run_sweep(1'b0);
      foreach (wq[k]) if (wq[k].a == vt[i].a) got = wq[k].d;
      check($sformatf("vec%0d data", i), got, vt[i].exp_d);
      check($sformatf("vec%0d bcderr", i), BcdErr, vt[i].exp_err);
    end

    fill(8'h37, 0);
    lat[4] = 15;
    run_sweep(1'b0);
    check_sweep("timeout");
    check("timeout req_len", req_len[4], 15);
    lat[4] = 14;
    run_sweep(1'b0);
    check_sweep("ack_on_15th");
    check("ack_on_15th req_len", req_len[4], 15);

    fill(8'h37, 0);
    mem[2] = 8'h3A;
    run_sweep(1'b1);
    check("set beats clear", bcd_at_write[2], 1);
    check("clear after set", BcdErr, 0);

    fill(8'h37, 3);
    VSync = 1'b1;
    tick();
    tick();
    clear_records();
    VSync = 1'b0;
    n = 0;
    while (!(RdReq && RdAddr == 4'd5) && n < 200) begin
      tick();
      n++;
    end
    check("reached addr5", {RdReq, RdAddr}, {1'b1, 4'd5});
    RESET = 1'b0;
    #1;
    check("async reset outputs", all_outputs(), 0);
    tick();
    VSync = 1'b1;
    tick();
    RESET = 1'b1;
    tick();
    tick();
    check("idle after mid reset", {Busy, RdReq}, 0);
    fill(8'h37, 0);
    run_sweep(1'b0);
    check_sweep("after_reset");

    fill(8'h11, 10);
    VSync = 1'b1;
    ClrErr = 1'b1;
    tick();
    ClrErr = 1'b0;
    tick();
    clear_records();
    VSync = 1'b0;
    n = 0;
    while (!(CS_DATA && MemAddrOut == 4'd6) && n < 400) begin
      tick();
      n++;
    end
    VSync = 1'b1;
    repeat (20) tick();
    check("overrun flag", Overrun, 1);
    check("overrun idle", {Busy, RdReq}, 0);
    check("overrun no sweepdone", sd_count, 0);
    check("overrun writes", wq.size(), 6);
    ClrErr = 1'b1;
    tick();
    ClrErr = 1'b0;
    tick();
    check("overrun cleared", Overrun, 0);
    fill(8'h37, 0);
    run_sweep(1'b0);
    check_sweep("post_overrun");

    for (int r = 0; r < 24; r++) begin
      for (int a = 0; a < 16; a++) begin
        if ($urandom_range(0, 3) == 0) mem[a] = 8'($urandom_range(0, 255));
        else mem[a] = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
        if ($urandom_range(0, 7) == 0) lat[a] = $urandom_range(13, 16);
        else lat[a] = $urandom_range(0, 3);
      end
      run_sweep(1'b0);
      check_sweep($sformatf("rand%0d", r));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, got no summary, expected completion");
    $fatal(1);
  end

endmodule
